// File: rtl/la_sram_wr_ctrl.sv
// rtl/la_sram_wr_ctrl.sv - ring-buffer SRAM write controller for the LA capture window
//
// Writes each {LA_RLE_CNT, LA_DATA} word from the RLE stage into external SRAM.
// A circular write pointer sets the address. The capture window runs through
// four phases: pre-trigger fill, armed (ring wraps freely), post-trigger
// countdown, and done. The trigger address is latched so that software can
// unroll the ring buffer.
//
// Optional feature macro: LA_STOP_FLUSH_EN
//   defined   - STOP forces one final write of the current RLE word, then DONE
//   undefined - STOP goes straight to DONE with no write
//
// Ports:
//   CLK, RST_N          clock (posedge) and asynchronous active-low reset
//   START, STOP         capture start / user abort pulses
//   TRIG                trigger level, sampled each cycle
//   PRE_CNT, POST_CNT   pre-trigger and post-trigger word counts
//   LA_DATA, LA_RLE_CNT word payload from the RLE stage
//   LA_WR_EN            word valid from the RLE stage
//   SRAM_ADDR/DATA/WE_N registered SRAM write port (WE_N active low)
//   TRIG_ADDR           write pointer captured at trigger acceptance
//   BUSY, TRIGGERED, WRAPPED, DONE  status
module la_sram_wr_ctrl #(
    parameter int ADDR_W = 19
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              TRIG,
    input  logic [ADDR_W-1:0] PRE_CNT,
    input  logic [ADDR_W-1:0] POST_CNT,
    input  logic [7:0]        LA_DATA,
    input  logic [7:0]        LA_RLE_CNT,
    input  logic              LA_WR_EN,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [15:0]       SRAM_DATA,
    output logic              SRAM_WE_N,
    output logic [ADDR_W-1:0] TRIG_ADDR,
    output logic              BUSY,
    output logic              TRIGGERED,
    output logic              WRAPPED,
    output logic              DONE
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   post_rem_q, post_rem_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic                triggered_q, triggered_d;
    logic                wrapped_q, wrapped_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [15:0]         sram_data_q, sram_data_d;
    logic                sram_we_n_q, sram_we_n_d;

    logic                do_write;
    logic                active;
    logic [ADDR_W-1:0]   wr_ptr_inc;
    logic [ADDR_W-1:0]   post_first_rem;

    assign active     = (state_q == ST_PREFILL) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign wr_ptr_inc = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    // A write coincident with the trigger already counts as the first post-trigger word.
    assign post_first_rem = POST_CNT - {{(ADDR_W-1){1'b0}}, LA_WR_EN};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        post_rem_d  = post_rem_q;
        trig_addr_d = trig_addr_q;
        triggered_d = triggered_q;
        wrapped_d   = wrapped_q;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;
        sram_we_n_d = 1'b1;
        do_write    = 1'b0;

        if (active && STOP) begin
            // The abort wins over the trigger and over a normal write in the same cycle.
`ifdef LA_STOP_FLUSH_EN
            do_write = 1'b1;
`endif
            state_d  = ST_DONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        wr_ptr_d    = '0;
                        triggered_d = 1'b0;
                        wrapped_d   = 1'b0;
                        trig_addr_d = '0;
                        state_d     = (PRE_CNT == '0) ? ST_ARMED : ST_PREFILL;
                    end
                end

                ST_PREFILL: begin
                    // The pointer starts at 0, so it equals the number of prefill words written.
                    if (LA_WR_EN) begin
                        do_write = 1'b1;
                        if (wr_ptr_inc == PRE_CNT) begin
                            state_d = ST_ARMED;
                        end
                    end
                end

                ST_ARMED: begin
                    if (TRIG) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        if (POST_CNT == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            do_write   = LA_WR_EN;
                            post_rem_d = post_first_rem;
                            state_d    = (post_first_rem == '0) ? ST_DONE : ST_POST;
                        end
                    end else if (LA_WR_EN) begin
                        do_write = 1'b1;
                    end
                end

                ST_POST: begin
                    if (LA_WR_EN) begin
                        do_write   = 1'b1;
                        post_rem_d = post_rem_q - {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (post_rem_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                            state_d = ST_DONE;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (do_write) begin
            sram_we_n_d = 1'b0;
            sram_addr_d = wr_ptr_q;
            sram_data_d = {LA_RLE_CNT, LA_DATA};
            wr_ptr_d    = wr_ptr_inc;
            if (wr_ptr_q == {ADDR_W{1'b1}}) begin
                wrapped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            post_rem_q  <= '0;
            trig_addr_q <= '0;
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            sram_we_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            post_rem_q  <= post_rem_d;
            trig_addr_q <= trig_addr_d;
            triggered_q <= triggered_d;
            wrapped_q   <= wrapped_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            sram_we_n_q <= sram_we_n_d;
        end
    end

    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_DATA = sram_data_q;
    assign SRAM_WE_N = sram_we_n_q;
    assign TRIG_ADDR = trig_addr_q;
    assign TRIGGERED = triggered_q;
    assign WRAPPED   = wrapped_q;
    assign BUSY      = active;
    assign DONE      = (state_q == ST_DONE);

endmodule

// File: tb/tb_la_sram_wr_ctrl.sv
// tb/tb_la_sram_wr_ctrl.sv - directed self-checking bench for la_sram_wr_ctrl
module tb_la_sram_wr_ctrl;

    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          START, STOP, TRIG, LA_WR_EN;
    logic [AW-1:0] PRE_CNT, POST_CNT;
    logic [7:0]    LA_DATA, LA_RLE_CNT;
    logic [AW-1:0] SRAM_ADDR, TRIG_ADDR;
    logic [15:0]   SRAM_DATA;
    logic          SRAM_WE_N, BUSY, TRIGGERED, WRAPPED, DONE;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int base;
    logic [AW-1:0] addr_log [0:255];

    la_sram_wr_ctrl #(.ADDR_W(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .TRIG(TRIG),
        .PRE_CNT(PRE_CNT), .POST_CNT(POST_CNT), .LA_DATA(LA_DATA),
        .LA_RLE_CNT(LA_RLE_CNT), .LA_WR_EN(LA_WR_EN), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DATA(SRAM_DATA), .SRAM_WE_N(SRAM_WE_N), .TRIG_ADDR(TRIG_ADDR),
        .BUSY(BUSY), .TRIGGERED(TRIGGERED), .WRAPPED(WRAPPED), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Log every SRAM write strobe, sampled away from the active edge.
    always @(negedge CLK) begin
        if (RST_N && !SRAM_WE_N) begin
            addr_log[we_count[7:0]] = SRAM_ADDR;
            we_count = we_count + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; STOP = 1'b0; TRIG = 1'b0; LA_WR_EN = 1'b0;
        PRE_CNT = '0; POST_CNT = '0; LA_DATA = '0; LA_RLE_CNT = '0;
        step(2);
        chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_data", 32'(SRAM_DATA), 32'd0);
        chk("rst_status", {28'd0, BUSY, TRIGGERED, WRAPPED, DONE}, 32'd0);
        chk("rst_trig_addr", 32'(TRIG_ADDR), 32'd0);
        RST_N = 1'b1;
        step(1);

        // T1: PRE=3, POST=2, trigger after 5 writes
        PRE_CNT = 4'd3; POST_CNT = 4'd2;
        START = 1'b1; step(1); START = 1'b0;
        chk("t1_busy", 32'(BUSY), 32'd1);
        base = we_count;
        LA_WR_EN = 1'b1;
        for (int i = 0; i < 7; i++) begin
            LA_DATA = 8'(i); LA_RLE_CNT = 8'(8'h10 + i); TRIG = (i == 5);
            step(1);
        end
        LA_WR_EN = 1'b0; TRIG = 1'b0;
        chk("t1_done", 32'(DONE), 32'd1);
        chk("t1_last_addr", 32'(SRAM_ADDR), 32'd6);
        chk("t1_last_data", 32'(SRAM_DATA), 32'h1606);
        step(1);
        chk("t1_we_pulses", 32'(we_count - base), 32'd7);
        for (int k = 0; k < 7; k++) chk("t1_addr_seq", 32'(addr_log[base + k]), 32'(k));
        chk("t1_trig_addr", 32'(TRIG_ADDR), 32'd5);
        chk("t1_triggered", 32'(TRIGGERED), 32'd1);
        chk("t1_wrapped", 32'(WRAPPED), 32'd0);
        chk("t1_busy_off", 32'(BUSY), 32'd0);

        // T2: wrap through the ring, trigger at pointer 20 mod 16
        PRE_CNT = 4'd2; POST_CNT = 4'd1;
        START = 1'b1; step(1); START = 1'b0;
        base = we_count;
        LA_WR_EN = 1'b1;
        step(20);
        TRIG = 1'b1; step(1); TRIG = 1'b0; LA_WR_EN = 1'b0;
        chk("t2_done", 32'(DONE), 32'd1);
        step(1);
        chk("t2_we_pulses", 32'(we_count - base), 32'd21);
        chk("t2_addr15", 32'(addr_log[base + 15]), 32'd15);
        chk("t2_addr16", 32'(addr_log[base + 16]), 32'd0);
        chk("t2_addr20", 32'(addr_log[base + 20]), 32'd4);
        chk("t2_trig_addr", 32'(TRIG_ADDR), 32'd4);
        chk("t2_wrapped", 32'(WRAPPED), 32'd1);

        // T3: TRIG held high from START is ignored during prefill
        PRE_CNT = 4'd4; POST_CNT = 4'd2;
        TRIG = 1'b1; START = 1'b1; step(1); START = 1'b0;
        chk("t3_wrapped_clr", 32'(WRAPPED), 32'd0);
        chk("t3_trig_clr", 32'(TRIGGERED), 32'd0);
        LA_WR_EN = 1'b1;
        step(4);
        chk("t3_prefill_ignores", 32'(TRIGGERED), 32'd0);
        step(1);
        chk("t3_triggered", 32'(TRIGGERED), 32'd1);
        chk("t3_trig_addr", 32'(TRIG_ADDR), 32'd4);
        chk("t3_post_busy", 32'(BUSY), 32'd1);
        step(1);
        LA_WR_EN = 1'b0; TRIG = 1'b0;
        chk("t3_done", 32'(DONE), 32'd1);

        // T4: PRE=0, POST=0, coincident write suppressed
        PRE_CNT = 4'd0; POST_CNT = 4'd0;
        START = 1'b1; step(1); START = 1'b0;
        chk("t4_armed_busy", 32'(BUSY), 32'd1);
        base = we_count;
        TRIG = 1'b1; LA_WR_EN = 1'b1; step(1); TRIG = 1'b0; LA_WR_EN = 1'b0;
        chk("t4_done", 32'(DONE), 32'd1);
        chk("t4_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("t4_trig_addr", 32'(TRIG_ADDR), 32'd0);
        step(1);
        chk("t4_no_write", 32'(we_count - base), 32'd0);
        STOP = 1'b1; step(1); STOP = 1'b0;
        chk("t4_stop_in_done", 32'(DONE), 32'd1);

        // T5: STOP in ARMED (with TRIG asserted) and LA_WR_EN low
        PRE_CNT = 4'd0; POST_CNT = 4'd3;
        LA_DATA = 8'hA5; LA_RLE_CNT = 8'h07;
        START = 1'b1; step(1); START = 1'b0;
        base = we_count;
        STOP = 1'b1; TRIG = 1'b1; step(1); STOP = 1'b0; TRIG = 1'b0;
        chk("t5_done", 32'(DONE), 32'd1);
        chk("t5_triggered", 32'(TRIGGERED), 32'd0);
`ifdef LA_STOP_FLUSH_EN
        chk("t5_flush_we_n", 32'(SRAM_WE_N), 32'd0);
        chk("t5_flush_data", 32'(SRAM_DATA), 32'h07A5);
        chk("t5_flush_addr", 32'(SRAM_ADDR), 32'd0);
        step(1);
        chk("t5_flush_count", 32'(we_count - base), 32'd1);
`else
        chk("t5_we_n", 32'(SRAM_WE_N), 32'd1);
        step(1);
        chk("t5_no_write", 32'(we_count - base), 32'd0);
`endif

        // T6: asynchronous reset during POST, then restart from address 0
        PRE_CNT = 4'd1; POST_CNT = 4'd5;
        START = 1'b1; step(1); START = 1'b0;
        LA_WR_EN = 1'b1;
        step(2);
        TRIG = 1'b1; step(1); TRIG = 1'b0;
        step(1);
        chk("t6_in_post", 32'(BUSY), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_async_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("t6_async_addr", 32'(SRAM_ADDR), 32'd0);
        chk("t6_async_data", 32'(SRAM_DATA), 32'd0);
        chk("t6_async_status", {28'd0, BUSY, TRIGGERED, WRAPPED, DONE}, 32'd0);
        chk("t6_async_trig_addr", 32'(TRIG_ADDR), 32'd0);
        #1 RST_N = 1'b1;
        LA_WR_EN = 1'b0;
        step(1);
        START = 1'b1; step(1); START = 1'b0;
        LA_WR_EN = 1'b1; LA_DATA = 8'h5A; LA_RLE_CNT = 8'h01;
        step(1);
        LA_WR_EN = 1'b0;
        chk("t6_restart_we_n", 32'(SRAM_WE_N), 32'd0);
        chk("t6_restart_addr", 32'(SRAM_ADDR), 32'd0);
        chk("t6_restart_data", 32'(SRAM_DATA), 32'h015A);
        chk("t6_restart_busy", 32'(BUSY), 32'd1);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
